// File: rtl/seven_seg_scan_decoder.sv
// Recovers the four glyphs shown on a multiplexed 7-segment display by sniffing anode/segs,
// debouncing each digit pattern and committing a frame once all four digit slots have been seen.
module seven_seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 1
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic [3:0] anode,
   input  logic [6:0] segs,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       frame_valid,
   output logic       frame_changed,
   output logic       anode_err
);

   localparam logic [7:0] ST = 8'(STABLE_CYCLES);

   typedef enum logic {COLLECT, COMMIT} state_t;

   state_t          state;
   logic [3:0]      anode_s, anode_p;
   logic [6:0]      segs_s, segs_p;
   logic [7:0]      cnt;
   logic [3:0]      seen;
   logic [3:0][3:0] stage;

   logic       is_blank, is_legal, is_illegal, same, accept;
   logic [3:0] sel, acc_mask;
   logic [7:0] cnt_nxt;
   logic [1:0] idx;
   logic [3:0] code;

   always_comb begin
      sel        = ~anode_s;
      is_blank   = (anode_s == 4'b1111);
      is_legal   = !is_blank && ((sel & (sel - 4'd1)) == 4'd0);
      is_illegal = !is_blank && !is_legal;
      same       = ({anode_s, segs_s} == {anode_p, segs_p});

      if (!is_legal)
         cnt_nxt = 8'd0;
      else if (!same)
         cnt_nxt = 8'd1;
      else if (cnt >= ST)
         cnt_nxt = ST;
      else
         cnt_nxt = cnt + 8'd1;

      // Accept only on the cycle the run first hits the threshold, never while it sits saturated.
      accept = is_legal && (cnt_nxt == ST) && (!same || (cnt != ST));

      idx = 2'd0;
      case (sel)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      acc_mask = accept ? (4'b0001 << idx) : 4'b0000;

      case (segs_s)
         7'b1111111: code = 4'h0;
         7'b0000111: code = 4'h1;
         7'b0011101: code = 4'h2;
         7'b1100011: code = 4'h3;
         7'b0110001: code = 4'h4;
         default:    code = 4'hF;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         anode_s       <= 4'b1111;
         anode_p       <= 4'b1111;
         segs_s        <= 7'b1111111;
         segs_p        <= 7'b1111111;
         cnt           <= 8'd0;
         seen          <= 4'd0;
         stage         <= '0;
         state         <= COLLECT;
         digit0        <= 4'h0;
         digit1        <= 4'h0;
         digit2        <= 4'h0;
         digit3        <= 4'h0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         anode_err     <= 1'b0;
      end else begin
         anode_s       <= anode;
         segs_s        <= segs;
         anode_p       <= anode_s;
         segs_p        <= segs_s;
         cnt           <= cnt_nxt;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;

         if (is_illegal)
            anode_err <= 1'b1;
         if (accept)
            stage[idx] <= code;

         case (state)
            COLLECT: begin
               if (seen == 4'b1111) begin
                  state         <= COMMIT;
                  digit0        <= stage[0];
                  digit1        <= stage[1];
                  digit2        <= stage[2];
                  digit3        <= stage[3];
                  frame_valid   <= 1'b1;
                  frame_changed <= (stage != {digit3, digit2, digit1, digit0});
                  // A slot landing on this edge already belongs to the next frame.
                  seen          <= acc_mask;
               end else begin
                  seen <= seen | acc_mask;
               end
            end
            COMMIT: begin
               state <= COLLECT;
               seen  <= seen | acc_mask;
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Random and directed scans into two decoders (thresholds 1 and 3) checked against a history-based model.
module tb_seven_seg_scan_decoder;

   logic       clk_in = 1'b0;
   logic       rst;
   logic [3:0] anode;
   logic [6:0] segs;
   logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
   logic       a_fv, a_fc, a_err, b_fv, b_fc, b_err;

   always #5 clk_in = ~clk_in;

   seven_seg_scan_decoder #(.STABLE_CYCLES(1)) dut1 (
      .clk_in(clk_in), .rst(rst), .anode(anode), .segs(segs),
      .digit0(a0), .digit1(a1), .digit2(a2), .digit3(a3),
      .frame_valid(a_fv), .frame_changed(a_fc), .anode_err(a_err));

   seven_seg_scan_decoder #(.STABLE_CYCLES(3)) dut3 (
      .clk_in(clk_in), .rst(rst), .anode(anode), .segs(segs),
      .digit0(b0), .digit1(b1), .digit2(b2), .digit3(b3),
      .frame_valid(b_fv), .frame_changed(b_fc), .anode_err(b_err));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [3:0]  PA [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0]  PS [4] = '{7'b0000111, 7'b0011101, 7'b1100011, 7'b0110001};
   logic [3:0]  ILL [9] = '{4'b1100, 4'b0011, 4'b0000, 4'b1010, 4'b0101,
                            4'b1001, 4'b0110, 4'b1000, 4'b0001};

   // Model: hist[e] is the pair sampled at edge e since reset; the pair sampled at edge e-1
   // is accepted at edge e when its run of identical consecutive samples is exactly N long.
   logic [10:0] hist [$];
   int unsigned nst [2] = '{1, 3};
   logic [3:0]  stg  [2][4];
   logic [3:0]  snap [2][4];
   logic [3:0]  ed   [2][4];
   logic [3:0]  seen [2];
   bit          pend [2];
   bit          efv [2], efc [2], eerr [2];
   int          fv_seen [2], fc_seen [2];

   function automatic logic [3:0] glyph(input logic [6:0] s);
      case (s)
         7'b1111111: return 4'h0;
         7'b0000111: return 4'h1;
         7'b0011101: return 4'h2;
         7'b1100011: return 4'h3;
         7'b0110001: return 4'h4;
         default:    return 4'hF;
      endcase
   endfunction

   function automatic logic [15:0] exp_digits(input int d);
      return {ed[d][3], ed[d][2], ed[d][1], ed[d][0]};
   endfunction

   task automatic model_clear();
      hist.delete();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            stg[d][i] = 4'h0; snap[d][i] = 4'h0; ed[d][i] = 4'h0;
         end
         seen[d] = 4'h0; pend[d] = 0; efv[d] = 0; efc[d] = 0; eerr[d] = 0;
      end
   endtask

   task automatic model_edge(input int d);
      int n, run, j, zeros, slot;
      logic [10:0] p;
      n = hist.size();
      efv[d] = 0;
      efc[d] = 0;
      if (pend[d]) begin
         efv[d] = 1;
         for (int i = 0; i < 4; i++) if (snap[d][i] != ed[d][i]) efc[d] = 1;
         for (int i = 0; i < 4; i++) ed[d][i] = snap[d][i];
         pend[d] = 0;
      end
      if (n >= 2) begin
         p = hist[n-2];
         zeros = 0;
         slot = 0;
         for (int i = 0; i < 4; i++) if (!p[7+i]) begin zeros++; slot = i; end
         if (zeros >= 2) eerr[d] = 1;
         else if (zeros == 1) begin
            run = 1;
            j = n - 3;
            while (j >= 0 && hist[j] == p) begin run++; j--; end
            if (run == int'(nst[d])) begin
               stg[d][slot] = glyph(p[6:0]);
               seen[d][slot] = 1'b1;
               if (seen[d] == 4'hF) begin
                  for (int i = 0; i < 4; i++) snap[d][i] = stg[d][i];
                  seen[d] = 4'h0;
                  pend[d] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("n1_digits", {16'h0, a3, a2, a1, a0}, {16'h0, exp_digits(0)});
      chk("n1_fv",  {31'h0, a_fv},  {31'h0, efv[0]});
      chk("n1_fc",  {31'h0, a_fc},  {31'h0, efc[0]});
      chk("n1_err", {31'h0, a_err}, {31'h0, eerr[0]});
      chk("n3_digits", {16'h0, b3, b2, b1, b0}, {16'h0, exp_digits(1)});
      chk("n3_fv",  {31'h0, b_fv},  {31'h0, efv[1]});
      chk("n3_fc",  {31'h0, b_fc},  {31'h0, efc[1]});
      chk("n3_err", {31'h0, b_err}, {31'h0, eerr[1]});
      if (a_fv) fv_seen[0]++;
      if (b_fv) fv_seen[1]++;
      if (a_fc) fc_seen[0]++;
      if (b_fc) fc_seen[1]++;
   endtask

   task automatic step(input logic [3:0] a, input logic [6:0] s);
      anode = a;
      segs  = s;
      @(posedge clk_in);
      #1;
      hist.push_back({a, s});
      for (int d = 0; d < 2; d++) model_edge(d);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_n1_out", {22'h0, a3, a2, a1, a0, a_fv, a_fc, a_err}, 32'h0);
      chk("rst_n3_out", {22'h0, b3, b2, b1, b0, b_fv, b_fc, b_err}, 32'h0);
      anode = 4'b1111;
      segs  = 7'b1111111;
      model_clear();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
   endtask

   task automatic scan(input int hold, input logic [6:0] seg2);
      for (int i = 0; i < 4; i++)
         repeat (hold) step(PA[i], (i == 2) ? seg2 : PS[i]);
      repeat (3) step(4'b1111, 7'b1111111);
   endtask

   initial begin
      int fv0, r, hold;
      logic [3:0] a;
      logic [6:0] s;
      rst = 1'b0;
      anode = 4'b1111;
      segs = 7'b1111111;
      fv_seen = '{0, 0};
      fc_seen = '{0, 0};
      @(posedge clk_in);
      #1;
      do_reset();

      scan(1, PS[2]);
      chk("scan1_digits", {16'h0, a3, a2, a1, a0}, 32'h4321);
      chk("scan1_fv_once", fv_seen[0], 1);
      chk("scan1_fc_once", fc_seen[0], 1);

      scan(1, PS[2]);
      chk("repeat_fv", fv_seen[0], 2);
      chk("repeat_fc_quiet", fc_seen[0], 1);

      step(PA[0], PS[0]);
      step(PA[1], PS[1]);
      step(4'b1100, PS[3]);
      step(PA[2], PS[2]);
      step(PA[3], PS[3]);
      repeat (3) step(4'b1111, 7'b1111111);
      chk("illegal_err_sticky", {31'h0, a_err}, 32'h1);
      chk("illegal_frame_done", fv_seen[0], 3);

      fv0 = fv_seen[1];
      scan(2, PS[2]);
      chk("n3_hold2_nocommit", fv_seen[1], fv0);
      scan(3, PS[2]);
      chk("n3_hold3_commit", fv_seen[1], fv0 + 1);
      chk("n3_digits_hold3", {16'h0, b3, b2, b1, b0}, 32'h4321);

      scan(1, 7'b1010101);
      chk("glyph_unknown", {28'h0, a2}, 32'hF);

      step(PA[0], PS[0]);
      step(PA[1], PS[1]);
      step(PA[1], PS[1]);
      do_reset();
      fv0 = fv_seen[0];
      step(PA[2], PS[2]);
      step(PA[3], PS[3]);
      repeat (3) step(4'b1111, 7'b1111111);
      chk("rst_partial_discard", fv_seen[0], fv0);
      scan(1, PS[2]);
      chk("rst_full_scan_commit", fv_seen[0], fv0 + 1);

      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 11);
         if (r == 0) a = 4'b1111;
         else if (r == 1) a = ILL[$urandom_range(0, 8)];
         else a = PA[$urandom_range(0, 3)];
         r = $urandom_range(0, 6);
         if (r < 4) s = PS[r];
         else if (r == 4) s = 7'b1111111;
         else s = 7'($urandom);
         hold = $urandom_range(1, 4);
         repeat (hold) step(a, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 1, is the number of consecutive identical samples (1..255) a digit pattern must show before it is accepted.
REQ-002 clk_in  input  1  system clock; all state SHALL change on its rising edge, except for reset.
REQ-003 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 anode  input  4  active-low digit select from the display multiplexer; bit i low selects digit i.
REQ-005 segs  input  7  active-low segment pattern for the selected digit, bit order segs[6:0].
REQ-006 digit0..digit3  output  4 each  decoded glyph code of the last complete frame.
REQ-007 frame_valid  output  1  one-cycle pulse when a new complete frame is latched.
REQ-008 frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when the latched frame differs from the previous one.
REQ-009 anode_err  output  1  sticky flag: an illegal anode pattern was sampled.

Function
REQ-010 anode and segs SHALL be registered once (sample stage) before any decision logic.
REQ-011 The sampled anode SHALL be classified as: legal, with exactly one bit low; blank, 4'b1111; or illegal, with two or more bits low.
REQ-012 An illegal sample SHALL set anode_err, clear the stability counter, and accept nothing.
REQ-013 A blank sample SHALL clear the stability counter, accept nothing, and leave anode_err unchanged.
REQ-014 Stability counter behaviour SHALL be:
 - increments (saturating at STABLE_CYCLES) while the sampled {anode,segs} pair equals the previous sample;
 - reloads to 1 on any change of the pair.
REQ-015 A legal pair SHALL be accepted exactly once per run, on the cycle the counter first reaches STABLE_CYCLES, and not re-accepted until the pair changes.
REQ-016 Glyph decode of segs SHALL be:
 - 7'b1111111 -> 4'h0 (blank)
 - 7'b0000111 -> 4'h1
 - 7'b0011101 -> 4'h2
 - 7'b1100011 -> 4'h3
 - 7'b0110001 -> 4'h4
 - any other pattern -> 4'hF (unknown)
REQ-017 On acceptance, the decoded code SHALL be written to staging slot i (the index of the low anode bit) and seen-mask bit i SHALL be set.
REQ-018 If a slot is accepted again before the frame completes, the latest code SHALL overwrite it (latest wins).
REQ-019 Two FSM states SHALL exist:
 - COLLECT: waits for seen-mask to become 4'b1111, then goes to COMMIT.
 - COMMIT: lasts one cycle; copies staging to digit0..3, pulses frame_valid, pulses frame_changed if any digit differs, clears seen-mask, returns to COLLECT.
REQ-020 A slot accepted in the same cycle as COMMIT SHALL count toward the next frame (its mask bit is set after the clear).
REQ-021 Latency with STABLE_CYCLES=1: if the completing pair is applied before edge k, it SHALL be sampled at k, accepted at k+1, and digit outputs with frame_valid SHALL update at edge k+2.
REQ-022 digit0..3 SHALL hold their values between commits; frame_valid and frame_changed SHALL be low except in the COMMIT cycle.
REQ-023 The first frame after reset SHALL be compared against all-zero outputs for frame_changed.

Reset
REQ-024 Asserting rst SHALL immediately force:
 - digit0..3 = 4'h0;
 - frame_valid, frame_changed, anode_err = 0;
 - seen-mask = 0, staging = 0, counter = 0;
 - sample registers = anode 4'b1111 / segs 7'b1111111;
 - FSM = COLLECT.
REQ-025 Reset mid-frame SHALL discard the partial frame; collection SHALL restart after rst deasserts.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
 - Scan 1110/0000111, 1101/0011101, 1011/1100011, 0111/0110001, one cycle each, STABLE_CYCLES=1 -> digits 1,2,3,4; frame_valid and frame_changed pulse once, two edges after the last pair.
 - Repeat the identical scan -> frame_valid pulses, frame_changed stays 0.
 - Apply anode=4'b1100 for one cycle mid-scan -> anode_err=1 and stays 1; no slot is written; the frame still completes once all four slots are seen.
 - STABLE_CYCLES=3; hold each pair 2 cycles -> no frame_valid; hold each pair 3 cycles -> frame commits.
 - segs=7'b1010101 on digit 2 -> digit2=4'hF.
 - Assert rst after two slots are accepted -> all outputs 0 immediately; after release, a full four-slot scan is needed before frame_valid.
